// File: rtl/spi_pkg.sv
// Shared types and constants for the configurable SPI master.
// State encoding, chip-select width helper and {cpol,cpha} mode codes.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    PH_A,
    PH_B,
    TRAIL
  } spi_state_t;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic int cs_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider for the SPI master: counts 0..HALF_DIV-1.
// tc_o marks the last system clock of each SCLK half-period.
module spi_clk_div #(
  parameter int HALF_DIV = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tc_o
);

  localparam int CW = $clog2(HALF_DIV);
  localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tc_o)
      cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_cfg.sv
// SPI master with runtime CPOL/CPHA, clock divider and several selects.
// Define SPI_MASTER_LSB_FIRST_EN to add the lsb_first port.
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter int  DATA_W   = 8,
  parameter int  HALF_DIV = 50,
  parameter int  NUM_CS   = 1,
  localparam int CS_W     = cs_width(NUM_CS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [CS_W-1:0]   cs_sel,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic [DATA_W-1:0] rx_data,
  output logic              tx_ready,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  spi_state_t        state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_q;
  logic [BW-1:0]     bit_q, bit_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic [CS_W-1:0]   sel_q, sel_d;
  logic              lsb_q, lsb_d;
  logic              sclk_q, sclk_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              done_q, done_d;
  logic              accept, div_clr, tc, lvl_a;

  assign accept  = start && (state_q == IDLE);
  assign div_clr = (state_q == IDLE);
  assign cpol_d  = accept ? cpol : cpol_q;
  assign cpha_d  = accept ? cpha : cpha_q;
  assign sel_d   = accept ? cs_sel : sel_q;
`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_d   = accept ? lsb_first : lsb_q;
`else
  assign lsb_d   = 1'b0;
`endif

  spi_clk_div #(
    .HALF_DIV(HALF_DIV)
  ) u_div (
    .clk  (clk),
    .reset(reset),
    .clr_i(div_clr),
    .tc_o (tc)
  );

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_sh_d = rx_sh_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE: begin
        bit_d = '0;
        if (start) begin
          state_d = LEAD;
          tx_d    = tx_data;
        end
      end
      LEAD: if (tc) state_d = PH_A;
      PH_A: begin
        if (tc) begin
          state_d = PH_B;
          if (lsb_q)
            rx_sh_d = {miso, rx_sh_q[DATA_W-1:1]};
          else
            rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
        end
      end
      PH_B: begin
        if (tc) begin
          if (bit_q == BIT_LAST) begin
            state_d = TRAIL;
          end else begin
            state_d = PH_A;
            bit_d   = bit_q + BW'(1);
            if (lsb_q)
              tx_d = {1'b0, tx_q[DATA_W-1:1]};
            else
              tx_d = {tx_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      TRAIL: if (tc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign done_d = (state_q == TRAIL) && tc;

  // Pins decode from the next state so SCLK edges align with state changes.
  always_comb begin
    lvl_a = 1'b0;
    unique case ({cpol_d, cpha_d})
      SPI_MODE0, SPI_MODE3: lvl_a = 1'b0;
      SPI_MODE1, SPI_MODE2: lvl_a = 1'b1;
      default:              lvl_a = 1'b0;
    endcase
    sclk_d = cpol_d;
    unique case (state_d)
      IDLE:    sclk_d = cpol;
      PH_A:    sclk_d = lvl_a;
      PH_B:    sclk_d = ~lvl_a;
      default: sclk_d = cpol_d;
    endcase
    cs_n_d = '1;
    if (state_d != IDLE) begin
      for (int i = 0; i < NUM_CS; i++) begin
        if (int'(sel_d) == i)
          cs_n_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sel_q   <= '0;
      lsb_q   <= 1'b0;
      sclk_q  <= 1'b0;
      cs_n_q  <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_sh_q <= rx_sh_d;
      bit_q   <= bit_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      sel_q   <= sel_d;
      lsb_q   <= lsb_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
      if (done_d)
        rx_q <= rx_sh_q;
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign done     = done_q;
  assign rx_data  = rx_q;
  assign sclk     = sclk_q;
  assign cs_n     = cs_n_q;
  assign mosi     = lsb_q ? tx_q[0] : tx_q[DATA_W-1];

endmodule

// File: tb/tb_spi_master_cfg.sv
// Self-checking bench for spi_master_cfg: frame table plus corner sequences.
// Build with SPI_MASTER_LSB_FIRST_EN to also exercise LSB-first frames.
module tb_spi_master_cfg;
  import spi_pkg::*;

  localparam int DW  = 8;
  localparam int HD  = 2;
  localparam int NCS = 5;
  localparam int CSW = cs_width(NCS);
  localparam int LAT = 2 * HD * (DW + 1);

  logic           clk;
  logic           reset;
  logic           start;
  logic [DW-1:0]  tx_data;
  logic           cpol;
  logic           cpha;
  logic [CSW-1:0] cs_sel;
  logic [DW-1:0]  rx_data;
  logic           tx_ready;
  logic           done;
  logic           sclk;
  logic           mosi;
  logic           miso;
  logic [NCS-1:0] cs_n;
  logic           loop_en;
  logic           miso_m;
`ifdef SPI_MASTER_LSB_FIRST_EN
  logic           lsb_in;
`endif

  int vecs = 0;
  int miscompares = 0;

  assign miso = loop_en ? mosi : miso_m;

  spi_master_cfg #(
    .DATA_W  (DW),
    .HALF_DIV(HD),
    .NUM_CS  (NCS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .tx_data  (tx_data),
    .cpol     (cpol),
    .cpha     (cpha),
    .cs_sel   (cs_sel),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first(lsb_in),
`endif
    .rx_data  (rx_data),
    .tx_ready (tx_ready),
    .done     (done),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .cs_n     (cs_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [DW-1:0]  tx;
    logic [DW-1:0]  slv;
    logic           cpol;
    logic           cpha;
    logic           lsb;
    logic           loopb;
    logic [CSW-1:0] sel;
    logic [DW-1:0]  exp_rx;
    logic [NCS-1:0] exp_cs;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [NCS-1:0] cs_model(input int sel);
    logic [NCS-1:0] m;
    m = '1;
    if (sel < NCS)
      m[sel] = 1'b0;
    return m;
  endfunction

  // Wire position of the k-th bit on the line.
  function automatic int bitpos(input int k, input logic lsb);
    return lsb ? k : DW - 1 - k;
  endfunction

  function automatic vec_t mk(input logic [DW-1:0] tx,
                              input logic [DW-1:0] slv,
                              input logic pol, input logic pha,
                              input int sel, input logic lsb,
                              input logic lb);
    vec_t v;
    v.tx     = tx;
    v.slv    = slv;
    v.cpol   = pol;
    v.cpha   = pha;
    v.sel    = CSW'(sel);
    v.lsb    = lsb;
    v.loopb  = lb;
    v.exp_rx = lb ? tx : slv;
    v.exp_cs = cs_model(sel);
    return v;
  endfunction

  task automatic drive_cfg(input vec_t v);
    tx_data = v.tx;
    cpol    = v.cpol;
    cpha    = v.cpha;
    cs_sel  = v.sel;
`ifdef SPI_MASTER_LSB_FIRST_EN
    lsb_in  = v.lsb;
`endif
  endtask

  task automatic run_frame(input vec_t v);
    int nd, lat, cs_bad, pol_bad, nedge, nsamp, k;
    logic prev, lead_e, first_ok;
    logic [DW-1:0] mw;
    nd = 0; lat = -1; cs_bad = 0; pol_bad = 0;
    nedge = 0; nsamp = 0; k = 0; mw = '0;
    first_ok = 1'b0;
    @(negedge clk);
    chk("ready_before_start", 32'(tx_ready), 32'd1);
    loop_en = v.loopb;
    drive_cfg(v);
    miso_m = v.slv[bitpos(0, v.lsb)];
    start  = 1'b1;
    prev   = v.cpol;
    for (int m = 0; m <= LAT + 3; m++) begin
      @(negedge clk);
      if (m == 0)
        first_ok = (mosi === v.tx[bitpos(0, v.lsb)]);
      if (done) begin
        nd++;
        if (lat < 0) lat = m;
      end
      if (m < LAT && cs_n !== v.exp_cs) cs_bad++;
      if (m == LAT && cs_n !== '1) cs_bad++;
      if (m < HD && sclk !== v.cpol) pol_bad++;
      if (m >= LAT - HD && m <= LAT + 3 && sclk !== v.cpol) pol_bad++;
      if (sclk !== prev) begin
        nedge++;
        lead_e = (sclk != v.cpol);
        if (lead_e ^ v.cpha) begin
          if (k < DW) mw[bitpos(k, v.lsb)] = mosi;
          nsamp++;
          k++;
          miso_m = (k < DW) ? v.slv[bitpos(k, v.lsb)] : 1'b0;
        end
        prev = sclk;
      end
      // Scramble inputs early in the frame; they must have no effect.
      if (m == 0) begin
        start = 1'b0;
      end else if (m <= LAT / 2) begin
        start   = 1'($urandom);
        tx_data = DW'($urandom);
        cpol    = 1'($urandom);
        cpha    = 1'($urandom);
        cs_sel  = CSW'($urandom);
      end else if (m == LAT / 2 + 1) begin
        start = 1'b0;
        drive_cfg(v);
      end
    end
    chk("first_mosi", 32'(first_ok), 32'd1);
    chk("done_latency", 32'(lat), 32'(LAT));
    chk("done_count", 32'(nd), 32'd1);
    chk("cs_n_frame", 32'(cs_bad), 32'd0);
    chk("sclk_idle_level", 32'(pol_bad), 32'd0);
    chk("sclk_edges", 32'(nedge), 32'(2 * DW));
    chk("sample_edges", 32'(nsamp), 32'(DW));
    chk("mosi_bits", 32'(mw), 32'(v.tx));
    chk("rx_data", 32'(rx_data), 32'(v.exp_rx));
  endtask

  task automatic b2b_test();
    int nd, d1, d2, cs_hi;
    vec_t v;
    nd = 0; d1 = -1; d2 = -1; cs_hi = 0;
    v = mk(8'h69, 8'h00, 1'b0, 1'b0, 2, 1'b0, 1'b1);
    @(negedge clk);
    loop_en = 1'b1;
    drive_cfg(v);
    start = 1'b1;
    for (int m = 0; m <= 2 * LAT + 4; m++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (d1 < 0) d1 = m;
        else d2 = m;
      end
      if (m <= 2 * LAT && cs_n === '1) cs_hi++;
      if (m == LAT + 5) start = 1'b0;
    end
    chk("b2b_done_count", 32'(nd), 32'd2);
    chk("b2b_first_done", 32'(d1), 32'(LAT));
    chk("b2b_second_done", 32'(d2), 32'(2 * LAT + 1));
    chk("b2b_cs_gap", 32'(cs_hi), 32'd1);
    chk("b2b_rx", 32'(rx_data), 32'h69);
  endtask

  task automatic reset_test();
    int nd;
    nd = 0;
    @(negedge clk);
    loop_en = 1'b0;
    miso_m  = 1'b1;
    drive_cfg(mk(8'h5A, 8'hFF, 1'b0, 1'b0, 1, 1'b0, 1'b0));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (HD + 2 * HD * 4) @(negedge clk);
    chk("rst_pre_cs", 32'(cs_n), 32'(cs_model(1)));
    reset = 1'b0;
    #1;
    chk("rst_async_cs", 32'(cs_n), 32'(cs_model(NCS)));
    @(negedge clk);
    chk("rst_cs", 32'(cs_n), 32'(cs_model(NCS)));
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_rx", 32'(rx_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    reset = 1'b1;
    for (int m = 0; m < LAT + 4; m++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("rst_no_done", 32'(nd), 32'd0);
    chk("rst_ready", 32'(tx_ready), 32'd1);
  endtask

  initial begin
    vec_t rv;
    reset   = 1'b0;
    start   = 1'b0;
    tx_data = '0;
    cpol    = 1'b0;
    cpha    = 1'b0;
    cs_sel  = '0;
    loop_en = 1'b0;
    miso_m  = 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
    lsb_in  = 1'b0;
`endif

    tbl.push_back(mk(8'hA5, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1));
    tbl.push_back(mk(8'h3C, 8'hC3, 1'b0, 1'b1, 1, 1'b0, 1'b0));
    tbl.push_back(mk(8'h3C, 8'hC3, 1'b1, 1'b0, 2, 1'b0, 1'b0));
    tbl.push_back(mk(8'h3C, 8'hC3, 1'b1, 1'b1, 3, 1'b0, 1'b0));
    tbl.push_back(mk(8'h5A, 8'h96, 1'b0, 1'b0, 2, 1'b0, 1'b0));
    tbl.push_back(mk(8'h3C, 8'hC3, 1'b0, 1'b0, 5, 1'b0, 1'b0));
    tbl.push_back(mk(8'hE7, 8'h18, 1'b1, 1'b0, 7, 1'b0, 1'b1));
`ifdef SPI_MASTER_LSB_FIRST_EN
    tbl.push_back(mk(8'h81, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b1));
    tbl.push_back(mk(8'h3C, 8'hC3, 1'b1, 1'b1, 4, 1'b1, 1'b0));
`endif
    for (int i = 0; i < 12; i++) begin
      rv = mk(DW'($urandom), DW'($urandom), 1'($urandom),
              1'($urandom), int'($urandom_range(0, 7)),
`ifdef SPI_MASTER_LSB_FIRST_EN
              1'($urandom),
`else
              1'b0,
`endif
              1'($urandom));
      tbl.push_back(rv);
    end

    repeat (3) @(negedge clk);
    chk("reset_cs_n", 32'(cs_n), 32'(cs_model(NCS)));
    chk("reset_sclk", 32'(sclk), 32'd0);
    chk("reset_rx", 32'(rx_data), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_mosi", 32'(mosi), 32'd0);
    chk("reset_ready", 32'(tx_ready), 32'd1);
    reset = 1'b1;
    cpol  = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_sclk_tracks_cpol", 32'(sclk), 32'd1);
    cpol = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      run_frame(tbl[i]);

    b2b_test();
    reset_test();
    run_frame(mk(8'hFF, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1));

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_master_cfg.md
Name: spi_master_cfg

Overview:
Parametrised successor to the team's fixed mode-0, 8-bit SPI master. It adds configurable frame width and clock divider, runtime CPOL/CPHA selection, and multiple active-low chip selects with lead and trail timing. It sits between an internal control FSM or register bank and off-chip SPI slaves, using the same start/tx_ready/done handshake as the existing master.

Parameters:
DATA_W, 8, frame width in bits (>=2)
HALF_DIV, 50, system clocks per SCLK half-period (>=2)
NUM_CS, 1, number of chip-select outputs (>=1)
CS_W, $clog2(NUM_CS) min 1, width of cs_sel (derived localparam)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  begin frame; honoured only when tx_ready=1
tx_data  in  DATA_W  frame to send; latched on an accepted start
cpol  in  1  SCLK idle level; latched on start
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on start
cs_sel  in  CS_W  slave index; latched on start
rx_data  out  DATA_W  last received frame; held until the next done
tx_ready  out  1  high in IDLE
done  out  1  one-cycle pulse at frame end
sclk  out  1  registered SPI clock
mosi  out  1  MSB of the tx shift register
miso  in  1  slave data
cs_n  out  NUM_CS  registered active-low selects

Behaviour:
- Reset (reset=0, async): state=IDLE, sclk=0, cs_n=all 1, rx_data=0, tx shift register=0 so mosi=0, done=0, counters=0. Reset mid-frame aborts immediately: cs_n releases and no done is generated.
- States: IDLE, LEAD, PH_A, PH_B, TRAIL. A divider counter counts 0..HALF_DIV-1 in every non-IDLE state. A bit counter counts 0..DATA_W-1.
- IDLE: tx_ready=1. sclk tracks the cpol input (registered). On start, latch tx_data, cpol, cpha and cs_sel, then go to LEAD.
- LEAD: HALF_DIV cycles. cs_n[sel]=0, sclk=cpol, mosi=bit DATA_W-1. This provides setup before the first edge.
- PH_A: HALF_DIV cycles, sclk=cpol^cpha. On the final cycle, shift miso into the rx shift register (MSB-first) and go to PH_B.
- PH_B: HALF_DIV cycles, sclk=~(cpol^cpha). On the final cycle:
  - if the bit counter is DATA_W-1, go to TRAIL;
  - otherwise left-shift tx and go to PH_A.
- TRAIL: HALF_DIV cycles, sclk=cpol, cs_n still asserted. On the final cycle, go to IDLE.
- On entering IDLE from TRAIL:
  - cs_n goes all 1;
  - rx_data is updated;
  - done=1 for exactly that cycle;
  - tx_ready=1 in the same cycle, so a start in that cycle is accepted (back-to-back frames; cs_n high for at least 1 cycle).
- sclk_next and cs_n_next are decoded from state_next, so SCLK edges coincide with the clk edge of the state change. miso is sampled on the same clk edge that makes the PH_A to PH_B SCLK edge.
- Latency: from the start-accept edge to done high is 2*HALF_DIV*(DATA_W+1) cycles.
- start while busy is ignored. Changes to tx_data, cpol, cpha or cs_sel mid-frame have no effect.
- cs_sel >= NUM_CS: the frame runs with all cs_n high, and done still pulses.
- Counters never exceed their terminal values. The bit counter resets to 0 in IDLE.

Optional Feature:
SPI_MASTER_LSB_FIRST_EN
- Defined: adds input port lsb_first (1 bit, latched on start). When it is 1, mosi=tx_reg[0], tx shifts right, and rx shifts in at the MSB (bit DATA_W-1).
- Undefined: the port is absent and the block is MSB-first only, identical to lsb_first=0.

Decomposition:
- Package spi_pkg holds:
  - state typedef spi_state_t {IDLE, LEAD, PH_A, PH_B, TRAIL};
  - localparam function for the CS_W computation;
  - mode encoding constants SPI_MODE0..SPI_MODE3 as {cpol,cpha}.
- One natural sub-module: spi_clk_div. It is a HALF_DIV counter with clear and a terminal-count output (tc), shared by all non-IDLE states. The FSM, shift registers and CS decode stay in the top level.

Test Plan:
- Mode 0, DATA_W=8, HALF_DIV=2, tx=0xA5, slave loopback (miso=mosi): done at cycle 36 after the start edge, rx_data=0xA5, and mosi bits observed at rising edges are 1,0,1,0,0,1,0,1.
- Modes 1/2/3, tx=0x3C, slave model returning 0xC3 per mode: rx_data=0xC3 in every mode, sclk idles at cpol, and 8 sampling edges occur on the correct polarity.
- NUM_CS=4, cs_sel=2: only cs_n[2] is low, from LEAD entry until done. cs_sel=5 gives cs_n=4'hF for the whole frame, and done still pulses.
- Back-to-back: start held high through done gives a second frame with cs_n high for exactly 1 cycle between frames. start pulses mid-frame are ignored (single done).
- reset dropped during bit 4: next cycle shows cs_n all 1, sclk=0, rx_data=0, no done. After release, a new frame with tx=0xFF completes normally.
- DATA_W=16, HALF_DIV=3, tx=0x8001, with SPI_MASTER_LSB_FIRST_EN and lsb_first=1: the first mosi bit is 1, rx_data=0x8001 in loopback, and done arrives at 102 cycles.
